div_issue: RTL and testbench
============================

Name: div_issue

Overview:
- EX-stage initiator for the multi-cycle divider's start/annul/ready handshake.
- Accepts a decoded DIV/DIVU from EX and drives start, signedness, operands and annul to the divider.
- Holds a pipeline stall request until the 64-bit result returns, then presents HI/LO and a HI/LO write enable to the EX/MEM register.
- Handles flush mid-operation and back-to-back divides.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W.
- WDOG_CYCLES, 40, number of BUSY cycles without ready_i before timeout_o asserts.

Ports:
- clk  in  1  clock; all registers rising-edge.
- rst  in  1  asynchronous, active-low reset.
- div_req_i  in  1  DIV/DIVU instruction present in EX.
- signed_i  in  1  1 = DIV, 0 = DIVU.
- op1_i  in  DATA_W  dividend.
- op2_i  in  DATA_W  divisor.
- stall_i  in  1  EX held by a later stage.
- flush_i  in  1  pipeline flush; kills the EX instruction.
- ready_i  in  1  divider result valid; held until start_o drops.
- result_i  in  2*DATA_W  {remainder, quotient} from divider.
- start_o  out  1  divider start; held through BUSY.
- signed_div_o  out  1  latched signedness.
- opdata1_o  out  DATA_W  latched dividend.
- opdata2_o  out  DATA_W  latched divisor.
- annul_o  out  1  cancel in-flight divide.
- stallreq_o  out  1  stall request to the pipeline controller.
- hi_o  out  DATA_W  remainder.
- lo_o  out  DATA_W  quotient.
- whilo_o  out  1  HI/LO write enable.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, any time, asynchronous): state IDLE; all outputs 0; operand and result registers 0.
- States: IDLE, BUSY, DONE.
- IDLE
  - If div_req_i=1 and flush_i=0:
    - stallreq_o=1 combinationally this cycle.
    - Latch signed_i, op1_i, op2_i; start_o<=1; go BUSY.
  - Otherwise: start_o=0, stallreq_o=0, whilo_o=0.
- BUSY
  - stallreq_o=1; start_o=1; operand outputs stable.
  - ready_i=1: latch hi<=result_i[63:32], lo<=result_i[31:0]; start_o<=0; go DONE.
  - flush_i=1 (takes priority over ready_i): annul_o=1 for exactly one cycle, start_o<=0, no HI/LO write, go IDLE.
  - Watchdog counter counts BUSY cycles. At WDOG_CYCLES it sets timeout_o, which stays set until reset; behaviour is otherwise unchanged.
- DONE
  - stallreq_o=0; whilo_o=1; hi_o/lo_o hold the latched result.
  - Stay while stall_i=1 and flush_i=0, so the held EX instruction keeps a stable result.
  - Go IDLE when stall_i=0 or flush_i=1.
  - The cycle after DONE is IDLE, so start_o is low for at least one cycle and the divider returns to free before any next start.
- Back-to-back divides: the second is accepted no earlier than the IDLE cycle after DONE.
- Latency: stallreq_o asserts in the request cycle; whilo_o asserts the cycle after ready_i is sampled in BUSY.
- Outputs are registered, except stallreq_o (combinational) and annul_o (combinational from BUSY & flush_i).

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined: in IDLE, a request with op2_i==0 never raises start_o. It goes straight to DONE with hi=lo=0, whilo_o=1 and stallreq_o=1 for the request cycle only; the divider is untouched.
- Undefined: divide-by-zero is issued to the divider like any other divide; the result (0/0) is whatever the divider returns.

Decomposition:
- Shared package/defines: state encodings (DIS_IDLE, DIS_BUSY, DIS_DONE); DivStart/DivStop values; DoubleRegBus width.
- Single sub-module div_issue_wdog: watchdog counter plus sticky timeout_o, cleared by rst.

Test Plan:
- DIVU 100/7 through a real divider → whilo_o=1, lo_o=0x0000000E, hi_o=0x00000002; stallreq_o high from request until the ready cycle.
- DIV -100/7 → lo_o=0xFFFFFFF2, hi_o=0xFFFFFFFE; signed_div_o=1 held through BUSY.
- flush_i pulsed 5 cycles into BUSY → annul_o one-cycle pulse, start_o low next cycle, whilo_o never high, state IDLE; the divider returns free.
- stall_i=1 for 3 cycles in DONE → whilo_o and hi_o/lo_o stable all 3 cycles; a second DIV then issues start_o only after one IDLE cycle.
- 5/0 with DIV_ZERO_BYPASS_EN → start_o never 1, whilo_o=1, hi_o=lo_o=0 the next cycle. Without the macro → the divider is started and the result is 0/0.
- Divider model never asserts ready_i → timeout_o=1 after 40 BUSY cycles. rst low mid-BUSY → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/div_issue_pkg.sv
// div_issue_pkg: shared definitions for the EX-stage divider issue logic.
// Holds the issue FSM state encoding, the divider start/stop levels and the
// register-bus widths used by div_issue and div_issue_wdog.
package div_issue_pkg;

    // Width of one general-purpose register and of a HI/LO pair.
    localparam int REG_W        = 32;
    localparam int DOUBLE_REG_W = 2 * REG_W;

    // Levels driven on the divider start line.
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Issue FSM states.
    //   DIS_IDLE : no divide in flight, ready to accept a DIV/DIVU
    //   DIS_BUSY : start held high, waiting for the divider's ready
    //   DIS_DONE : result latched, HI/LO write enable presented
    typedef enum logic [1:0] {
        DIS_IDLE = 2'd0,
        DIS_BUSY = 2'd1,
        DIS_DONE = 2'd2
    } dis_state_t;

endpackage

// File: rtl/div_issue_wdog.sv
// div_issue_wdog: watchdog for the divider issue FSM.
// Counts consecutive BUSY cycles. When the count reaches WDOG_CYCLES the
// sticky timeout flag is set and stays set until the asynchronous reset.
// The counter restarts from zero every time BUSY is left.
module div_issue_wdog #(
    parameter int WDOG_CYCLES = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WDOG_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Count BUSY cycles, saturating at WDOG_CYCLES; clear outside BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!busy) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky timeout: set on the WDOG_CYCLES-th BUSY cycle, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_o <= 1'b0;
        end else if (busy && (cnt == CNT_LAST)) begin
            timeout_o <= 1'b1;
        end
    end

endmodule

// File: rtl/div_issue.sv
// div_issue: EX-stage initiator for the multi-cycle divider.
//
// Accepts a decoded DIV/DIVU from EX, drives start/signedness/operands/annul
// to the divider, holds a pipeline stall request until the divider's
// {remainder, quotient} result returns, then presents HI/LO with a write
// enable to the EX/MEM register.
//
// Divider handshake (start/annul/ready):
//   - start_o rises with the operands latched and stays high for the whole
//     BUSY period; opdata1_o/opdata2_o/signed_div_o are stable while it is high.
//   - ready_i is raised by the divider with result_i valid and is held until
//     start_o drops; a result is taken in the first BUSY cycle ready_i is seen.
//   - annul_o is a single-cycle cancel (BUSY and flush_i); start_o drops on
//     the following cycle and no HI/LO write is made.
//   - After every result start_o is low for at least one cycle (DONE then
//     IDLE), so the divider is free before the next start.
//
// Optional build macro DIV_ZERO_BYPASS_EN: when defined, a divide by zero is
// completed locally (HI=LO=0) without ever starting the divider.
//
// dbg_state_o exposes the FSM state for observation.
import div_issue_pkg::*;

module div_issue #(
    parameter int DATA_W      = REG_W,
    parameter int WDOG_CYCLES = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_req_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   op1_i,
    input  logic [DATA_W-1:0]   op2_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                ready_i,
    input  logic [2*DATA_W-1:0] result_i,
    output logic                start_o,
    output logic                signed_div_o,
    output logic [DATA_W-1:0]   opdata1_o,
    output logic [DATA_W-1:0]   opdata2_o,
    output logic                annul_o,
    output logic                stallreq_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                whilo_o,
    output logic                timeout_o,
    output logic [1:0]          dbg_state_o
);

    dis_state_t state;
    logic       accept;
    logic       busy;

    // A request is taken only from IDLE and only when it is not being flushed.
    assign accept = (state == DIS_IDLE) && div_req_i && !flush_i;
    assign busy   = (state == DIS_BUSY);

    // Stall from the request cycle until the result has been captured.
    assign stallreq_o = accept || busy;

    // Cancel is a pure function of BUSY and flush; BUSY is left on the same
    // edge, so the pulse is exactly one cycle long.
    assign annul_o = busy && flush_i;

    assign dbg_state_o = state;

    // Issue FSM with registered divider-side and HI/LO-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= DIS_IDLE;
            start_o      <= DIV_STOP;
            signed_div_o <= 1'b0;
            opdata1_o    <= '0;
            opdata2_o    <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
            whilo_o      <= 1'b0;
        end else begin
            case (state)
                DIS_IDLE: begin
                    if (accept) begin
`ifdef DIV_ZERO_BYPASS_EN
                        if (op2_i == '0) begin
                            // Divide by zero finishes here; the divider is left alone.
                            hi_o    <= '0;
                            lo_o    <= '0;
                            whilo_o <= 1'b1;
                            state   <= DIS_DONE;
                        end else begin
                            signed_div_o <= signed_i;
                            opdata1_o    <= op1_i;
                            opdata2_o    <= op2_i;
                            start_o      <= DIV_START;
                            state        <= DIS_BUSY;
                        end
`else
                        signed_div_o <= signed_i;
                        opdata1_o    <= op1_i;
                        opdata2_o    <= op2_i;
                        start_o      <= DIV_START;
                        state        <= DIS_BUSY;
`endif
                    end else begin
                        start_o <= DIV_STOP;
                        whilo_o <= 1'b0;
                    end
                end

                DIS_BUSY: begin
                    if (flush_i) begin
                        // Flush wins over a coincident ready: drop the result.
                        start_o <= DIV_STOP;
                        state   <= DIS_IDLE;
                    end else if (ready_i) begin
                        hi_o    <= result_i[2*DATA_W-1:DATA_W];
                        lo_o    <= result_i[DATA_W-1:0];
                        start_o <= DIV_STOP;
                        whilo_o <= 1'b1;
                        state   <= DIS_DONE;
                    end
                end

                DIS_DONE: begin
                    // Hold the result while EX is stalled so the held
                    // instruction keeps seeing a stable HI/LO.
                    if (flush_i || !stall_i) begin
                        whilo_o <= 1'b0;
                        state   <= DIS_IDLE;
                    end
                end

                default: begin
                    start_o <= DIV_STOP;
                    whilo_o <= 1'b0;
                    state   <= DIS_IDLE;
                end
            endcase
        end
    end

    div_issue_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .timeout_o (timeout_o)
    );

endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: directed bench for div_issue with a behavioural divider that
// answers a fixed number of cycles after start, or never when never_ready=1.
module tb_div_issue;

  localparam int DW  = 32;
  localparam int LAT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          div_req_i = 1'b0;
  logic          signed_i = 1'b0;
  logic [DW-1:0] op1_i = '0;
  logic [DW-1:0] op2_i = '0;
  logic          stall_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          ready_i;
  logic [2*DW-1:0] result_i;
  logic          start_o;
  logic          signed_div_o;
  logic [DW-1:0] opdata1_o;
  logic [DW-1:0] opdata2_o;
  logic          annul_o;
  logic          stallreq_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          whilo_o;
  logic          timeout_o;
  logic [1:0]    dbg_state_o;

  int n_chk = 0;
  int n_bad = 0;
  int starts = 0;
  int stall_gaps;
  int sign_gaps;
  logic never_ready = 1'b0;
  logic prev_start;
  int div_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  div_issue #(.DATA_W(DW), .WDOG_CYCLES(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .signed_i     (signed_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .ready_i      (ready_i),
    .result_i     (result_i),
    .start_o      (start_o),
    .signed_div_o (signed_div_o),
    .opdata1_o    (opdata1_o),
    .opdata2_o    (opdata2_o),
    .annul_o      (annul_o),
    .stallreq_o   (stallreq_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .whilo_o      (whilo_o),
    .timeout_o    (timeout_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- divider model ----------------
  function automatic logic [2*DW-1:0] div_ref(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (b == '0) return '0;
    if (s) return {DW'($signed(a) % $signed(b)), DW'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_i  <= 1'b0;
      result_i <= '0;
      div_cnt  <= 0;
    end else if (!start_o || annul_o) begin
      ready_i <= 1'b0;
      div_cnt <= 0;
    end else if (!ready_i && !never_ready) begin
      if (div_cnt == LAT - 1) begin
        ready_i  <= 1'b1;
        result_i <= div_ref(signed_div_o, opdata1_o, opdata2_o);
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  // Count divider start rising edges.
  always @(posedge clk) begin
    prev_start <= start_o;
    if (start_o && !prev_start) starts <= starts + 1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    signed_i  = s;
    op1_i     = a;
    op2_i     = b;
    div_req_i = 1'b1;
  endtask

  // Step negedges until whilo_o rises, tallying stall and signedness gaps.
  task automatic wait_whilo(input string tag, input logic want_sign);
    bit seen = 0;
    stall_gaps = 0;
    sign_gaps  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      div_req_i = 1'b0;
      if (whilo_o) begin
        seen = 1;
        break;
      end
      if (!stallreq_o) stall_gaps++;
      if (dbg_state_o == ST_BUSY && signed_div_o != want_sign) sign_gaps++;
    end
    chk({tag, " result_arrived"}, 64'(seen), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", 64'(start_o), 64'd0);
    chk("rst_whilo", 64'(whilo_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("rst_stallreq", 64'(stallreq_o), 64'd0);

    // DIVU 100/7
    issue(1'b0, 32'd100, 32'd7);
    #1 chk("divu_stallreq_req", 64'(stallreq_o), 64'd1);
    wait_whilo("divu", 1'b0);
    chk("divu_stall_gaps", 64'(stall_gaps), 64'd0);
    chk("divu_lo", 64'(lo_o), 64'h0000000E);
    chk("divu_hi", 64'(hi_o), 64'h00000002);
    chk("divu_done_stallreq", 64'(stallreq_o), 64'd0);
    chk("divu_done_start", 64'(start_o), 64'd0);
    @(negedge clk);
    chk("divu_back_idle", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("divu_whilo_drop", 64'(whilo_o), 64'd0);

    // DIV -100/7
    issue(1'b1, 32'hFFFFFF9C, 32'd7);
    @(negedge clk);
    div_req_i = 1'b0;
    chk("div_start", 64'(start_o), 64'd1);
    chk("div_opdata1", 64'(opdata1_o), 64'hFFFFFF9C);
    wait_whilo("div", 1'b1);
    chk("div_sign_gaps", 64'(sign_gaps), 64'd0);
    chk("div_lo", 64'(lo_o), 64'hFFFFFFF2);
    chk("div_hi", 64'(hi_o), 64'hFFFFFFFE);
    @(negedge clk);

    // flush 5 cycles into BUSY
    issue(1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    div_req_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("flush_pre_state", 64'(dbg_state_o), 64'(ST_BUSY));
    chk("flush_pre_annul", 64'(annul_o), 64'd0);
    flush_i = 1'b1;
    #1 chk("flush_annul", 64'(annul_o), 64'd1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_annul_drop", 64'(annul_o), 64'd0);
    chk("flush_start_low", 64'(start_o), 64'd0);
    chk("flush_state", 64'(dbg_state_o), 64'(ST_IDLE));
    begin
      int w = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (whilo_o || ready_i) w++;
      end
      chk("flush_no_write", 64'(w), 64'd0);
    end
    chk("flush_hilo_kept", {hi_o, lo_o}, 64'hFFFFFFFE_FFFFFFF2);

    // stall for 3 cycles in DONE, then back-to-back DIV
    stall_i = 1'b1;
    issue(1'b0, 32'd50, 32'd6);
    wait_whilo("stall", 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("stall_whilo_%0d", i), 64'(whilo_o), 64'd1);
      chk($sformatf("stall_hilo_%0d", i), {hi_o, lo_o}, {32'd2, 32'd8});
    end
    stall_i = 1'b0;
    issue(1'b1, 32'd9, 32'd2);
    #1 chk("b2b_done_stallreq", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    chk("b2b_idle_gap_state", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("b2b_idle_gap_start", 64'(start_o), 64'd0);
    chk("b2b_idle_stallreq", 64'(stallreq_o), 64'd1);
    @(negedge clk);
    div_req_i = 1'b0;
    chk("b2b_start", 64'(start_o), 64'd1);
    wait_whilo("b2b", 1'b1);
    chk("b2b_hilo", {hi_o, lo_o}, {32'd1, 32'd4});
    @(negedge clk);

    // divide by zero
    s0 = starts;
    issue(1'b0, 32'd5, 32'd0);
    #1 chk("dz_stallreq_req", 64'(stallreq_o), 64'd1);
`ifdef DIV_ZERO_BYPASS_EN
    @(negedge clk);
    div_req_i = 1'b0;
    chk("dz_state", 64'(dbg_state_o), 64'(ST_DONE));
    chk("dz_whilo", 64'(whilo_o), 64'd1);
    chk("dz_hilo", {hi_o, lo_o}, 64'd0);
    chk("dz_start", 64'(start_o), 64'd0);
    chk("dz_stallreq_done", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    chk("dz_starts", 64'(starts - s0), 64'd0);
`else
    @(negedge clk);
    div_req_i = 1'b0;
    chk("dz_start", 64'(start_o), 64'd1);
    wait_whilo("dz", 1'b0);
    chk("dz_hilo", {hi_o, lo_o}, 64'd0);
    chk("dz_starts", 64'(starts - s0), 64'd1);
    @(negedge clk);
`endif

    // watchdog
    never_ready = 1'b1;
    issue(1'b0, 32'd77, 32'd3);
    @(negedge clk);
    div_req_i = 1'b0;
    repeat (39) @(negedge clk);
    chk("wdog_before", 64'(timeout_o), 64'd0);
    @(negedge clk);
    chk("wdog_after", 64'(timeout_o), 64'd1);
    chk("wdog_still_busy", 64'({start_o, stallreq_o}), 64'd3);
    repeat (3) @(negedge clk);
    chk("wdog_sticky", 64'(timeout_o), 64'd1);

    // asynchronous reset mid-BUSY
    #2 rst = 1'b0;
    #1;
    chk("arst_start", 64'(start_o), 64'd0);
    chk("arst_stallreq", 64'(stallreq_o), 64'd0);
    chk("arst_timeout", 64'(timeout_o), 64'd0);
    chk("arst_ops", {opdata1_o, opdata2_o}, 64'd0);
    chk("arst_hilo", {hi_o, lo_o}, 64'd0);
    chk("arst_misc", 64'({signed_div_o, whilo_o, annul_o}), 64'd0);
    chk("arst_state", 64'(dbg_state_o), 64'(ST_IDLE));
    never_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_release_state", 64'(dbg_state_o), 64'(ST_IDLE));

    // final report
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
